// File: rtl/aoi21_bist_pkg.sv
// Shared types and constants for the AOI21 cell self-test checker.
package aoi21_bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // Expected ZN for vec = {A, B1, B2}: high only while A=0 and B1&B2=0
    localparam logic [7:0] EXP_ZN_MAP = 8'h07;
    localparam logic [7:0] MISR_POLY  = 8'h1D;
    localparam logic [7:0] MISR_SEED  = 8'h00;
    localparam logic [3:0] FAIL_MAX   = 4'd15;

endpackage

// File: rtl/misr_shift_reg.sv
// Single-input MISR: shift left, fold feedback polynomial on carry-out, XOR in the new bit.
module misr_shift_reg #(
    parameter int unsigned       SIG_W = 8,
    parameter logic [SIG_W-1:0] POLY  = '0,
    parameter logic [SIG_W-1:0] SEED  = '0
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_sig_next;

    always_comb begin
        w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                   ^ (r_sig[SIG_W-1] ? POLY : '0)
                   ^ {{(SIG_W-1){1'b0}}, din};
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_sig <= SEED;
        end else if (clr) begin
            r_sig <= SEED;
        end else if (en) begin
            r_sig <= w_sig_next;
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/aoi21_bist_checker.sv
// Sweeps all A/B1/B2 combinations into an AOI21 cell, compares ZN against the
// ideal function and compresses every sample into a MISR signature.
module aoi21_bist_checker
    import aoi21_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1,
    parameter int unsigned SIG_W         = 8
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             start,
    input  logic             zn_in,
    output logic             a_o,
    output logic             b1_o,
    output logic             b2_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       fail_count,
    output logic [SIG_W-1:0] signature
);

    state_e     r_state, w_state_d;
    logic [2:0] r_vec, w_vec_d;
    logic [3:0] r_cnt, w_cnt_d;
    logic [1:0] r_sweep, w_sweep_d;
    logic [3:0] r_fail, w_fail_d;
    logic       r_a, r_b1, r_b2, r_busy, r_done, r_pass;
    logic       w_a_d, w_b1_d, w_b2_d, w_busy_d, w_done_d, w_pass_d;
    logic       w_sample, w_mismatch, w_clr;

    assign w_sample   = (r_state == RUN) && (r_cnt == 4'(SETTLE_CYCLES));
    assign w_mismatch = (zn_in != EXP_ZN_MAP[r_vec]);
    assign w_clr      = start && (r_state != RUN);

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state <= IDLE;
            r_vec   <= 3'd0;
            r_cnt   <= 4'd0;
            r_sweep <= 2'd0;
            r_fail  <= 4'd0;
            r_a     <= 1'b0;
            r_b1    <= 1'b0;
            r_b2    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_vec   <= w_vec_d;
            r_cnt   <= w_cnt_d;
            r_sweep <= w_sweep_d;
            r_fail  <= w_fail_d;
            r_a     <= w_a_d;
            r_b1    <= w_b1_d;
            r_b2    <= w_b2_d;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
            r_pass  <= w_pass_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_vec_d   = r_vec;
        w_cnt_d   = r_cnt;
        w_sweep_d = r_sweep;
        w_fail_d  = r_fail;
        unique case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_d = RUN;
                    w_vec_d   = 3'd0;
                    w_cnt_d   = 4'd0;
                    w_sweep_d = 2'd0;
                    w_fail_d  = 4'd0;
                end
            end
            RUN: begin
                if (w_sample) begin
                    w_cnt_d = 4'd0;
                    w_vec_d = r_vec + 3'd1;
                    if (w_mismatch && (r_fail != FAIL_MAX)) begin
                        w_fail_d = r_fail + 4'd1;
                    end
                    if (r_vec == 3'd7) begin
                        w_sweep_d = r_sweep + 2'd1;
                        if (r_sweep == 2'(PASSES - 1)) begin
                            w_state_d = DONE;
                        end
                    end
                end else begin
                    w_cnt_d = r_cnt + 4'd1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    // Outputs are decoded from next state so every port comes straight off a flop
    always_comb begin
        w_a_d    = (w_state_d == RUN) && w_vec_d[2];
        w_b1_d   = (w_state_d == RUN) && w_vec_d[1];
        w_b2_d   = (w_state_d == RUN) && w_vec_d[0];
        w_busy_d = (w_state_d == RUN);
        w_done_d = (w_state_d == DONE);
        w_pass_d = (w_state_d == DONE) && (w_fail_d == 4'd0);
    end

    misr_shift_reg #(
        .SIG_W (SIG_W),
        .POLY  (SIG_W'(MISR_POLY)),
        .SEED  (SIG_W'(MISR_SEED))
    ) u_misr (
        .CK  (CK),
        .RN  (RN),
        .clr (w_clr),
        .en  (w_sample),
        .din (zn_in),
        .sig (signature)
    );

    assign a_o        = r_a;
    assign b1_o       = r_b1;
    assign b2_o       = r_b2;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign fail_count = r_fail;

endmodule

// File: tb/tb_aoi21_bist_checker.sv
// Self-checking bench: three checker instances (defaults, PASSES=4, SETTLE_CYCLES=1)
// driven by behavioural cells with programmable per-vector ZN responses.
module tb_aoi21_bist_checker;

    logic       CK = 1'b0;
    logic       RN;
    logic [2:0] start, done, busy, pss, a, b1, b2, zn;
    logic [3:0] fc   [3];
    logic [7:0] sig  [3];
    logic [7:0] resp [3];
    int errors = 0;
    int checks = 0;

    always #5 CK = ~CK;

    // Each cell answers with resp[vec]; resp = 8'h07 is a healthy AOI21
    assign zn[0] = resp[0][{a[0], b1[0], b2[0]}];
    assign zn[1] = resp[1][{a[1], b1[1], b2[1]}];
    assign zn[2] = resp[2][{a[2], b1[2], b2[2]}];

    aoi21_bist_checker #(.SETTLE_CYCLES(2), .PASSES(1), .SIG_W(8)) u_dut0 (
        .CK(CK), .RN(RN), .start(start[0]), .zn_in(zn[0]), .a_o(a[0]), .b1_o(b1[0]),
        .b2_o(b2[0]), .busy(busy[0]), .done(done[0]), .pass(pss[0]), .fail_count(fc[0]),
        .signature(sig[0]));

    aoi21_bist_checker #(.SETTLE_CYCLES(2), .PASSES(4), .SIG_W(8)) u_dut1 (
        .CK(CK), .RN(RN), .start(start[1]), .zn_in(zn[1]), .a_o(a[1]), .b1_o(b1[1]),
        .b2_o(b2[1]), .busy(busy[1]), .done(done[1]), .pass(pss[1]), .fail_count(fc[1]),
        .signature(sig[1]));

    aoi21_bist_checker #(.SETTLE_CYCLES(1), .PASSES(1), .SIG_W(8)) u_dut2 (
        .CK(CK), .RN(RN), .start(start[2]), .zn_in(zn[2]), .a_o(a[2]), .b1_o(b1[2]),
        .b2_o(b2[2]), .busy(busy[2]), .done(done[2]), .pass(pss[2]), .fail_count(fc[2]),
        .signature(sig[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the samples the run should take and apply the AOI21 truth
    // function and the MISR recurrence arithmetically.
    task automatic model(input logic [7:0] r, input int passes, output int fails,
                         output logic [7:0] s);
        logic z, ideal, top;
        fails = 0;
        s     = 8'h00;
        for (int p = 0; p < passes; p++) begin
            for (int v = 0; v < 8; v++) begin
                ideal = !(v[2] || (v[1] && v[0]));
                z     = r[v];
                if (z != ideal && fails < 15) fails++;
                top = s[7];
                s   = (s << 1) ^ (top ? 8'h1D : 8'h00) ^ {7'd0, z};
            end
        end
    endtask

    task automatic run_check(input int id, input logic [7:0] r, input int passes,
                             input int settle, input bit toggle, input string tag);
        int n;
        int lat;
        int exp_f;
        logic [7:0] exp_s;
        lat = 8 * passes * (settle + 1);
        model(r, passes, exp_f, exp_s);
        @(negedge CK);
        resp[id]  = r;
        start[id] = 1'b1;
        @(negedge CK);
        start[id] = 1'b0;
        n = 0;
        check({tag, " busy"}, 32'(busy[id]), 32'd1);
        check({tag, " done_low"}, 32'(done[id]), 32'd0);
        while (done[id] !== 1'b1 && n < lat + 20) begin
            if (toggle) start[id] = 1'($urandom_range(1, 0));
            if (id == 2 && !toggle && n < 16)
                check({tag, " vec"}, 32'({a[id], b1[id], b2[id]}), 32'(n / 2));
            @(negedge CK);
            n++;
        end
        start[id] = 1'b0;
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " done"}, 32'(done[id]), 32'd1);
        check({tag, " busy_off"}, 32'(busy[id]), 32'd0);
        check({tag, " pass"}, 32'(pss[id]), 32'(exp_f == 0));
        check({tag, " fail_count"}, 32'(fc[id]), 32'(exp_f));
        check({tag, " signature"}, 32'(sig[id]), 32'(exp_s));
        check({tag, " abc_idle"}, 32'({a[id], b1[id], b2[id]}), 32'd0);
    endtask

    initial begin
        int n;
        RN    = 1'b0;
        start = 3'b000;
        resp[0] = 8'h07;
        resp[1] = 8'h07;
        resp[2] = 8'h07;
        repeat (2) @(negedge CK);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset pass", 32'(pss), 32'd0);
        check("reset abc", 32'({a, b1, b2}), 32'd0);
        check("reset fail_count", 32'(fc[0]), 32'd0);
        check("reset signature", 32'(sig[0]), 32'd0);
        RN = 1'b1;

        run_check(0, 8'h07, 1, 2, 1'b0, "good");
        run_check(0, 8'h00, 1, 2, 1'b0, "stuck0");
        run_check(1, 8'hFF, 4, 2, 1'b0, "stuck1_p4");

        // Asynchronous reset in the middle of vec 4
        @(negedge CK);
        resp[0]  = 8'h07;
        start[0] = 1'b1;
        @(negedge CK);
        start[0] = 1'b0;
        n = 0;
        while ({a[0], b1[0], b2[0]} != 3'd4 && n < 40) begin
            @(negedge CK);
            n++;
        end
        check("midrun reach vec4", 32'(n < 40), 32'd1);
        check("midrun sig nonzero", 32'(sig[0] != 8'h00), 32'd1);
        #2 RN = 1'b0;
        #1;
        check("async busy", 32'(busy[0]), 32'd0);
        check("async abc", 32'({a[0], b1[0], b2[0]}), 32'd0);
        check("async signature", 32'(sig[0]), 32'd0);
        check("async fail_count", 32'(fc[0]), 32'd0);
        check("async done", 32'(done[0]), 32'd0);
        @(negedge CK);
        RN = 1'b1;
        run_check(0, 8'h07, 1, 2, 1'b0, "after_reset");

        run_check(0, 8'h07, 1, 2, 1'b1, "start_toggle");
        run_check(0, 8'h07, 1, 2, 1'b0, "restart_done");
        run_check(2, 8'h07, 1, 1, 1'b0, "settle1");

        for (int i = 0; i < 4; i++) run_check(0, 8'($urandom), 1, 2, 1'b0, "rand_p1");
        for (int i = 0; i < 2; i++) run_check(1, 8'($urandom), 4, 2, 1'b0, "rand_p4");
        run_check(2, 8'($urandom), 1, 1, 1'b0, "rand_s1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
